bram_sdp_clr: RTL

- Parametrised simple-dual-port block RAM: one write port (A) with byte enables, one read port (B) with a valid strobe.
- Selectable read latency of 1 or 2 cycles.
- Hardware clear sequencer zeroes the whole array after reset or on request.
- Used as the general-purpose storage macro for the accelerator's feature and weight buffers.

---
 rtl/bram_pkg.sv | 17 +
 rtl/bram_clr_seq.sv | 62 ++++++
 rtl/bram_sdp_clr.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// Shared types and helpers for the clearable simple-dual-port RAM.
// No logic; imported by the sequencer and the top.
package bram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic byte_par(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bram_clr_seq.sv
// Clear sequencer: walks addresses 0..DEPTH-1, one word per cycle, while busy.
// clr_done is asserted in the cycle the last word is written (combinational from state).
module bram_clr_seq
  import bram_pkg::*;
#(
  parameter int DEPTH      = 1600,
  parameter bit CLR_ON_RST = 1'b1,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_start,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_done
);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          last;

  assign last     = (cnt == AW'(DEPTH - 1));
  assign clr_addr = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // clr_start is only honoured in IDLE, so a re-pulse cannot stretch a clear.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          clr_done  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/bram_sdp_clr.sv
// Simple-dual-port byte-enable RAM with hardware clear; read latency 1 (OUT_REG=0) or 2.
// Optional per-byte parity with b_perr output when BRAM_PARITY_EN is defined.
module bram_sdp_clr
  import bram_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 1600,
  parameter  int OUT_REG    = 0,
  parameter  int RDW_NEW    = 0,
  parameter  int CLR_ON_RST = 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int NB         = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_we,
  input  logic [NB-1:0]    a_be,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_din,
  output logic             a_ready,
  input  logic             b_re,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_dout,
  output logic             b_valid,
  input  logic             clr_start,
  output logic             busy,
  output logic             clr_done
`ifdef BRAM_PARITY_EN
  ,
  output logic [NB-1:0]    b_perr
`endif
);

`ifdef BRAM_PARITY_EN
  localparam int LW = BYTE_W + 1;
`else
  localparam int LW = BYTE_W;
`endif

  (* ram_style = "block" *) logic [NB-1:0][LW-1:0] mem [DEPTH];

  logic [AW-1:0]         clr_addr;
  logic                  a_in_rng, b_in_rng, a_acc, rd_acc;
  logic [AW-1:0]         wr_addr;
  logic [NB-1:0]         wr_lane;
  logic [NB-1:0][LW-1:0] wdat;
  logic [NB-1:0][LW-1:0] ram_q;
  logic [WIDTH-1:0]      byp_dat_q;
  logic [NB-1:0]         byp_q;
  logic                  in_rng_q, vld1;
  logic [WIDTH-1:0]      dout1;

  bram_clr_seq #(
    .DEPTH      (DEPTH),
    .CLR_ON_RST (CLR_ON_RST != 0),
    .AW         (AW)
  ) u_clr_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_addr  (clr_addr),
    .clr_done  (clr_done)
  );

  assign a_ready  = !busy;
  assign a_in_rng = ({1'b0, a_addr} < (AW+1)'(DEPTH));
  assign b_in_rng = ({1'b0, b_addr} < (AW+1)'(DEPTH));
  assign a_acc    = a_we & a_ready & a_in_rng;
  assign rd_acc   = b_re & !busy;

  // The clear owns the write port while busy; user writes are simply not accepted.
  assign wr_addr = busy ? clr_addr : a_addr;
  assign wr_lane = busy ? {NB{1'b1}} : (a_acc ? a_be : '0);

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      wdat[i] = '0;
      if (!busy) begin
        wdat[i][BYTE_W-1:0] = a_din[i*BYTE_W +: BYTE_W];
`ifdef BRAM_PARITY_EN
        wdat[i][BYTE_W] = byte_par(a_din[i*BYTE_W +: BYTE_W]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_lane[i]) mem[wr_addr][i] <= wdat[i];
    end
  end

  // Read-first array port; same-address bypass is merged after the array.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      ram_q     <= mem[b_addr];
      byp_dat_q <= a_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1     <= 1'b0;
      in_rng_q <= 1'b0;
      byp_q    <= '0;
    end else begin
      vld1 <= rd_acc;
      if (rd_acc) begin
        in_rng_q <= b_in_rng;
        byp_q    <= ((RDW_NEW != 0) && a_acc && (a_addr == b_addr)) ? a_be : '0;
      end
    end
  end

`ifdef BRAM_PARITY_EN
  logic [NB-1:0] perr1;
`endif

  always_comb begin
    dout1 = '0;
`ifdef BRAM_PARITY_EN
    perr1 = '0;
`endif
    if (in_rng_q) begin
      for (int i = 0; i < NB; i++) begin
        dout1[i*BYTE_W +: BYTE_W] = byp_q[i] ? byp_dat_q[i*BYTE_W +: BYTE_W]
                                             : ram_q[i][BYTE_W-1:0];
`ifdef BRAM_PARITY_EN
        perr1[i] = !byp_q[i] && (ram_q[i][BYTE_W] != byte_par(ram_q[i][BYTE_W-1:0]));
`endif
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic             vld2;
      logic [WIDTH-1:0] dout2;
`ifdef BRAM_PARITY_EN
      logic [NB-1:0]    perr2;
`endif
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld2  <= 1'b0;
          dout2 <= '0;
`ifdef BRAM_PARITY_EN
          perr2 <= '0;
`endif
        end else begin
          vld2 <= vld1;
          if (vld1) dout2 <= dout1;
`ifdef BRAM_PARITY_EN
          perr2 <= vld1 ? perr1 : '0;
`endif
        end
      end
      assign b_valid = vld2;
      assign b_dout  = dout2;
`ifdef BRAM_PARITY_EN
      assign b_perr  = perr2;
`endif
    end else begin : g_noreg
      assign b_valid = vld1;
      assign b_dout  = dout1;
`ifdef BRAM_PARITY_EN
      assign b_perr  = vld1 ? perr1 : '0;
`endif
    end
  endgenerate

endmodule
